// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Holds the opcode encodings, the controller state type and the bit positions
// of the result flags. The flags vector is packed as {negative, zero, carry, overflow}.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StDone = 2'b10
    } alu_state_e;

    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU.
// master: issues operations (in_valid, x, y, sel) and accepts results (out_ready).
// slave:  the ALU; returns in_ready, out_valid, z (2W bits) and flags {N, Z, C, V}.
interface alu_seq_if #(
    parameter int unsigned W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2:0]     sel;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] z;
    logic [3:0]     flags;

    modport master (
        output in_valid, x, y, sel, out_ready,
        input  in_ready, out_valid, z, flags
    );

    modport slave (
        input  in_valid, x, y, sel, out_ready,
        output in_ready, out_valid, z, flags
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned multiplier, one multiplier bit per cycle.
// clk, rst : clock, asynchronous active-high reset
// start_i  : load a_i/b_i and begin W shift-add steps
// done_o   : high during the cycle whose closing edge performs the final step
// product_o: accumulated product, held until the next start
module alu_mul_seq #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);
    localparam int unsigned CW = $clog2(W + 1);

    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = CW'(W);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Last step happens at the edge that ends the cycle with one step remaining.
    assign done_o    = (cnt_q == CW'(1));
    assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides.
// clk, rst : clock, asynchronous active-high reset
// bus      : alu_seq_if slave (operands/opcode in, 2W-bit result and {N,Z,C,V} out)
// Single-cycle ops finish at the accepting edge; MUL runs W cycles in alu_mul_seq.
// The result is held in DONE until out_ready; z/flags read zero when out_valid is low.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int unsigned SW = $clog2(2 * W);

    alu_state_e     state_q, state_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   y_q, y_d;
    logic [2:0]     sel_q, sel_d;

    logic           accept;
    logic           mul_start;
    logic           mul_done;
    logic [2*W-1:0] mul_product;

    assign accept    = bus.in_valid && (state_q == StIdle);
    assign mul_start = accept && (bus.sel == OP_MUL);

    alu_mul_seq #(
        .W(W)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mul_start),
        .a_i      (bus.x),
        .b_i      (bus.y),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sel_d   = sel_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    x_d     = bus.x;
                    y_d     = bus.y;
                    sel_d   = bus.sel;
                    state_d = (bus.sel == OP_MUL) ? StMul : StDone;
                end
            end
            StMul: begin
                if (mul_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            sel_q   <= OP_ADD;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
        end
    end

    // Result datapath from captured operands; stable for the whole DONE state.
    logic [W:0]     sum;
    logic [W-1:0]   narrow;
    logic [2*W-1:0] wide;
    logic [3*W-1:0] shl_full;
    logic           is_wide;
    logic           carry;
    logic           ovf;
    logic [2*W-1:0] res_z;
    logic [3:0]     res_f;

    always_comb begin
        sum      = '0;
        narrow   = '0;
        wide     = '0;
        shl_full = '0;
        is_wide  = 1'b0;
        carry    = 1'b0;
        ovf      = 1'b0;
        unique case (sel_q)
            OP_ADD: begin
                sum    = {1'b0, x_q} + {1'b0, y_q};
                narrow = sum[W-1:0];
                carry  = sum[W];
                ovf    = (x_q[W-1] == y_q[W-1]) && (narrow[W-1] != x_q[W-1]);
            end
            OP_SUB: begin
                sum    = {1'b0, x_q} - {1'b0, y_q};
                narrow = sum[W-1:0];
                carry  = sum[W];  // borrow out: x < y unsigned
                ovf    = (x_q[W-1] != y_q[W-1]) && (narrow[W-1] != x_q[W-1]);
            end
            OP_AND: narrow = x_q & y_q;
            OP_OR:  narrow = x_q | y_q;
            OP_XOR: narrow = x_q ^ y_q;
            OP_NOT: narrow = ~x_q;
            OP_MUL: begin
                is_wide = 1'b1;
                wide    = mul_product;
                ovf     = |mul_product[2*W-1:W];
            end
            OP_SHL: begin
                // 3W-bit shift keeps the bits pushed past 2W-1 visible for overflow.
                is_wide  = 1'b1;
                shl_full = {{(2 * W){1'b0}}, x_q} << y_q[SW-1:0];
                wide     = shl_full[2*W-1:0];
                ovf      = |shl_full[3*W-1:2*W];
            end
        endcase

        res_z         = is_wide ? wide : {{W{1'b0}}, narrow};
        res_f         = '0;
        res_f[FLAG_N] = is_wide ? 1'b0 : narrow[W-1];
        res_f[FLAG_Z] = is_wide ? ~|wide : ~|narrow;
        res_f[FLAG_C] = carry;
        res_f[FLAG_V] = ovf;
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.z         = bus.out_valid ? res_z : '0;
    assign bus.flags     = bus.out_valid ? res_f : '0;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=8): directed literal cases plus random
// operations compared every cycle against a transaction-level model.
module tb_alu_seq;
    localparam int W = 8;

    logic clk;
    logic rst;

    alu_seq_if #(.W(W)) bus ();

    alu_seq #(.W(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference result {z[15:0], N, Z, C, V} from plain integer arithmetic.
    function automatic logic [19:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] s);
        int     ua, ub, sa, sb, r;
        longint full;
        logic [15:0] zz;
        logic   n, zf, c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c = 1'b0;
        v = 1'b0;
        zz = '0;
        full = 0;
        case (s)
            3'd0: begin
                r = ua + ub;
                zz = 16'(r % (1 << W));
                c = (r >= (1 << W));
                v = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            3'd1: begin
                r = ua - ub + (1 << W);
                zz = 16'(r % (1 << W));
                c = (ua < ub);
                v = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            3'd2: zz = 16'(ua & ub);
            3'd3: zz = 16'(ua | ub);
            3'd4: zz = 16'(ua ^ ub);
            3'd5: zz = 16'(255 - ua);
            3'd6: begin
                full = longint'(ua) * longint'(ub);
                zz = 16'(full);
                v = (full >= (1 << W));
            end
            default: begin
                full = longint'(ua) << (ub % (2 * W));
                zz = 16'(full % (1 << (2 * W)));
                v = (full >= (1 << (2 * W)));
            end
        endcase
        if (s >= 3'd6) begin
            n = 1'b0;
        end else begin
            n = zz[W-1];
        end
        zf = (zz == 16'd0);
        return {zz, n, zf, c, v};
    endfunction

    // Transaction model: busy from acceptance until consumption, result valid
    // from the edge count at which it becomes available.
    int           cyc = 0;
    bit           m_busy = 1'b0;
    int           m_valid_at = 0;
    logic [19:0]  m_res = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 1'b0;
            end else begin
                if (m_busy) begin
                    if (cyc >= m_valid_at && bus.out_ready) m_busy = 1'b0;
                end else if (bus.in_valid) begin
                    m_busy = 1'b1;
                    m_valid_at = cyc + 1 + ((bus.sel == 3'd6) ? W : 0);
                    m_res = model(bus.x, bus.y, bus.sel);
                end
                cyc++;
            end
        end
    end

    // Per-cycle comparison, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_in_ready", longint'(bus.in_ready), 1);
                check("rst_out_valid", longint'(bus.out_valid), 0);
                check("rst_z", longint'(bus.z), 0);
                check("rst_flags", longint'(bus.flags), 0);
            end else begin
                check("in_ready", longint'(bus.in_ready), longint'(!m_busy));
                check("out_valid", longint'(bus.out_valid),
                      longint'(m_busy && cyc >= m_valid_at));
                if (m_busy && cyc >= m_valid_at) begin
                    check("z", longint'(bus.z), longint'(m_res[19:4]));
                    check("flags", longint'(bus.flags), longint'(m_res[3:0]));
                end
            end
        end
    end

    // Issue one op from idle, hold the result for 'hold' cycles while pushing
    // ignored requests, then consume it. lat counts edges from acceptance to valid.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                         input int hold, output int lat, output logic [15:0] rz,
                         output logic [3:0] rf);
        bus.in_valid = 1'b1;
        bus.x = a;
        bus.y = b;
        bus.sel = s;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) check("result_timeout", 0, 1);
        rz = bus.z;
        rf = bus.flags;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.x = 8'($urandom);
            bus.y = 8'($urandom);
            bus.sel = 3'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;  // must be ignored at the consuming edge
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    int          lat;
    logic [15:0] rz;
    logic [3:0]  rf;
    logic [19:0] pin;

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.sel = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Pin the model itself against hand-computed values.
        pin = model(8'hAF, 8'hAF, 3'd0);
        check("model_add", longint'(pin), longint'({16'h005E, 4'b0011}));
        pin = model(8'h00, 8'h01, 3'd1);
        check("model_sub", longint'(pin), longint'({16'h00FF, 4'b1010}));
        pin = model(8'hAF, 8'hAF, 3'd6);
        check("model_mul", longint'(pin), longint'({16'h77A1, 4'b0001}));

        do_op(8'hAF, 8'hAF, 3'd0, 0, lat, rz, rf);
        check("add_lat", lat, 1);
        check("add_z", longint'(rz), 'h005E);
        check("add_flags", longint'(rf), 'b0011);

        do_op(8'hAF, 8'hAF, 3'd1, 1, lat, rz, rf);
        check("sub_eq_z", longint'(rz), 'h0000);
        check("sub_eq_flags", longint'(rf), 'b0100);

        do_op(8'h00, 8'h01, 3'd1, 0, lat, rz, rf);
        check("sub_brw_z", longint'(rz), 'h00FF);
        check("sub_brw_flags", longint'(rf), 'b1010);

        do_op(8'hAF, 8'hAF, 3'd6, 2, lat, rz, rf);
        check("mul_lat", lat, W + 1);
        check("mul_z", longint'(rz), 'h77A1);
        check("mul_flags", longint'(rf), 'b0001);

        do_op(8'h81, 8'h11, 3'd7, 0, lat, rz, rf);
        check("shl1_z", longint'(rz), 'h0102);
        check("shl1_flags", longint'(rf), 'b0000);

        do_op(8'h81, 8'h0F, 3'd7, 0, lat, rz, rf);
        check("shl15_z", longint'(rz), 'h8000);
        check("shl15_flags", longint'(rf), 'b0001);

        do_op(8'h0F, 8'h00, 3'd5, 0, lat, rz, rf);
        check("not_z", longint'(rz), 'h00F0);
        check("not_flags", longint'(rf), 'b1000);

        // Backpressure: five stalled cycles, checked every cycle by the model.
        do_op(8'h3C, 8'h0F, 3'd4, 5, lat, rz, rf);
        check("xor_z", longint'(rz), 'h0033);

        // Reset mid-MUL takes effect without a clock edge.
        bus.in_valid = 1'b1;
        bus.x = 8'hAF;
        bus.y = 8'hAF;
        bus.sel = 3'd6;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_out_valid", longint'(bus.out_valid), 0);
        check("async_in_ready", longint'(bus.in_ready), 1);
        check("async_z", longint'(bus.z), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        do_op(8'h01, 8'h01, 3'd0, 0, lat, rz, rf);
        check("post_rst_lat", lat, 1);
        check("post_rst_z", longint'(rz), 'h0002);

        // Random operations; the per-cycle checker compares against the model.
        for (int k = 0; k < 150; k++) begin
            logic [7:0] ra, rb;
            logic [2:0] rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (($urandom % 4) == 0) rb = ra;
            rs = 3'($urandom_range(0, 7));
            do_op(ra, rb, rs, int'($urandom_range(0, 3)), lat, rz, rf);
            check("rand_lat", lat, (rs == 3'd6) ? W + 1 : 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter W, default 8, operand width (W >= 4).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 x  input  W  operand A.
REQ-007 y  input  W  operand B.
REQ-008 sel  input  3  opcode.
REQ-009 out_valid  output  1  result held on z/flags.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 z  output  2W  result.
REQ-012 flags  output  4  {negative, zero, carry, overflow}.

Function
REQ-013 The opcode map SHALL be:
- 000 ADD
- 001 SUB (x-y)
- 010 AND
- 011 OR
- 100 XOR
- 101 NOT x
- 110 MUL (unsigned)
- 111 SHL (x << y[log2(2W)-1:0])
REQ-014 The FSM SHALL have states IDLE, MUL, DONE.
- IDLE: in_ready=1.
- MUL and DONE: in_ready=0.
REQ-015 An operation SHALL be accepted when in_valid && in_ready at a rising edge; x, y and sel SHALL be captured internally at that edge.
REQ-016 For a non-MUL opcode, the FSM SHALL go IDLE->DONE at the accepting edge, giving out_valid one cycle after acceptance.
REQ-017 For MUL, the FSM SHALL go IDLE->MUL, run a shift-add on one multiplier bit per cycle, and go MUL->DONE after exactly W cycles, giving out_valid W+1 cycles after acceptance.
REQ-018 In DONE, out_valid SHALL be 1 and z/flags SHALL be stable until the edge where out_ready=1; the FSM then SHALL go DONE->IDLE.
REQ-019 No new operation SHALL be accepted in the cycle the result is consumed; the next acceptance is possible one cycle later.
REQ-020 For ADD, SUB and logic ops, z SHALL be the W-bit result zero-extended to 2W; NOT SHALL invert only the low W bits.
REQ-021 carry SHALL be:
- ADD: carry-out.
- SUB: borrow, i.e. 1 when x<y unsigned.
- Other opcodes: 0.
REQ-022 overflow SHALL be:
- ADD/SUB: two's-complement signed overflow of the W-bit result.
- MUL: 1 when z[2W-1:W] != 0.
- SHL: 1 when any 1 bit is shifted beyond bit 2W-1.
- Other opcodes: 0.
REQ-023 zero SHALL be 1 when the W-bit result (ADD/SUB/logic) or the 2W-bit result (MUL/SHL) is 0.
REQ-024 negative SHALL be the MSB of the W-bit result for ADD/SUB/logic, and 0 for MUL/SHL.
REQ-025 A shift amount >= 2W SHALL wrap modulo 2W.
REQ-026 in_valid while in_ready=0 SHALL be ignored, with no state change.

Reset
REQ-027 While rst=1, the FSM SHALL be IDLE and outputs SHALL be: in_ready=1, out_valid=0, z=0, flags=0.
REQ-028 Assertion of rst mid-MUL or in DONE SHALL discard the operation immediately, without waiting for a clock edge.
REQ-029 The first acceptance after reset SHALL be possible at the first rising edge with rst=0.

Structure
REQ-030 A shared package alu_pkg SHALL hold:
- the opcode constants OP_ADD..OP_SHL
- the FSM state enum
- flag bit index constants
REQ-031 The iterative multiplier SHALL be a sub-module alu_mul_seq (start, done, W-cycle shift-add); all other ops SHALL be computed inline from the captured operands.

Verification (W=8)
REQ-032 ADD: x=AF, y=AF -> one cycle later out_valid=1, z=005E, flags {N=0, Z=0, C=1, V=1}.
REQ-033 SUB: x=AF, y=AF -> z=0000, flags {N=0, Z=1, C=0, V=0}; SUB x=00, y=01 -> z=00FF, C=1, N=1.
REQ-034 MUL: x=AF, y=AF -> out_valid exactly 9 cycles after acceptance, z=77A1, V=1; in_ready=0 throughout.
REQ-035 Backpressure: out_ready=0 for 5 cycles after any result -> z/flags unchanged and out_valid=1 every cycle; a new in_valid is ignored until the cycle after consumption.
REQ-036 Reset mid-MUL: assert rst 3 cycles after a MUL acceptance -> immediately out_valid=0 and in_ready=1; after release, ADD x=01, y=01 -> z=0002.
REQ-037 SHL: x=81, y=11 (shift 1) -> z=0102, V=0; SHL x=81, y=0F -> z=8000, V=1.
